// File: rtl/avalon_master_lsu.sv
// avalon_master_lsu
// Avalon-MM master that turns one core fetch/load/store request at a time
// into a single 32-bit bus transfer, then returns one response strobe.
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   req_*             core request (valid/ready handshake, accepted in IDLE)
//   resp_*            one-cycle response: right-aligned read data, error flag
//   avm_*             Avalon-MM master port (read/write, byteenable, wait)
//
// Parameter:
//   TIMEOUT_CYCLES    max cycles a transfer may stall in BUS; 0 = no limit
module avalon_master_lsu #(
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [3:0]  avm_byteenable,
    output logic [31:0] avm_writedata,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t      state, state_nx;
    logic [1:0]  size_q;
    logic [1:0]  ofs_q;
    logic        signed_q;
    logic        write_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [31:0] tcnt;
    logic        bus_timeout;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] ofs);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return ofs[0];
            2'b10:   return ofs != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] ofs);
        case (size)
            2'b00:   return 4'b0001 << ofs;
            2'b01:   return 4'b0011 << ofs;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicating the store data across lanes lets byteenable alone pick the lane.
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [1:0] size, input logic [1:0] ofs,
                                            input logic sgn, input logic [31:0] rd);
        logic [31:0] sh;
        sh = rd >> {ofs, 3'b000};
        case (size)
            2'b00:   return {{24{sgn & sh[7]}}, sh[7:0]};
            2'b01:   return {{16{sgn & sh[15]}}, sh[15:0]};
            default: return rd;
        endcase
    endfunction

    // Counter value T-1 marks the last allowed BUS cycle.
    assign bus_timeout = (TIMEOUT_CYCLES != 0) && avm_waitrequest &&
                         (tcnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (req_valid)
                      state_nx = is_misaligned(req_size, req_addr[1:0]) ? RESP : BUS;
            BUS:  if (!avm_waitrequest || bus_timeout)
                      state_nx = RESP;
            RESP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Response outputs are gated by state so they read 0 outside RESP.
    always_comb begin
        req_ready  = (state == IDLE) && !reset;
        avm_read   = (state == BUS) && !write_q;
        avm_write  = (state == BUS) && write_q;
        resp_valid = (state == RESP);
        resp_error = (state == RESP) && err_q;
        resp_rdata = (state == RESP) ? rdata_q : 32'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            avm_address    <= 32'd0;
            avm_byteenable <= 4'd0;
            avm_writedata  <= 32'd0;
            size_q         <= 2'd0;
            ofs_q          <= 2'd0;
            signed_q       <= 1'b0;
            write_q        <= 1'b0;
            err_q          <= 1'b0;
            rdata_q        <= 32'd0;
            tcnt           <= 32'd0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    avm_address    <= {req_addr[31:2], 2'b00};
                    avm_byteenable <= lane_be(req_size, req_addr[1:0]);
                    avm_writedata  <= lane_wdata(req_size, req_wdata);
                    size_q         <= req_size;
                    ofs_q          <= req_addr[1:0];
                    signed_q       <= req_signed;
                    write_q        <= req_write;
                    err_q          <= is_misaligned(req_size, req_addr[1:0]);
                    rdata_q        <= 32'd0;
                    tcnt           <= 32'd0;
                end
                BUS: begin
                    tcnt <= tcnt + 32'd1;
                    if (!avm_waitrequest) begin
                        err_q   <= 1'b0;
                        rdata_q <= write_q ? 32'd0 : extract(size_q, ofs_q, signed_q, avm_readdata);
                    end else if (bus_timeout) begin
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_master_lsu.sv
// tb_avalon_master_lsu
// Self-checking bench for avalon_master_lsu (TIMEOUT_CYCLES = 4). Each
// transaction is driven from a negedge, and every following cycle of bus
// command and response is compared against a transaction-level model built
// from plain arithmetic on the request fields.
module tb_avalon_master_lsu;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_error;
    logic [31:0] resp_rdata;
    logic [31:0] avm_address, avm_writedata, avm_readdata;
    logic        avm_read, avm_write, avm_waitrequest;
    logic [3:0]  avm_byteenable;

    int checks = 0;
    int errors = 0;

    logic [31:0] last_rdata, last_addr, last_wd;
    logic [3:0]  last_be;
    logic        last_err;
    int          last_cmd, last_resp;

    avalon_master_lsu #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic m_err(input logic [31:0] addr, input logic [1:0] sz);
        if (sz == 2'd3) return 1'b1;
        return (addr % (32'd1 << sz)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [31:0] addr, input logic [1:0] sz);
        int o = int'(addr[1:0]);
        if (sz == 2'd0) return 4'(1 << o);
        if (sz == 2'd1) return 4'(3 << o);
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'd0) return {24'd0, wd[7:0]} * 32'h01010101;
        if (sz == 2'd1) return {16'd0, wd[15:0]} * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] m_rd(input logic [31:0] addr, input logic [1:0] sz,
                                         input logic sg, input logic [31:0] rd);
        int          nbits = 8 << sz;
        logic [31:0] mask, v;
        if (sz == 2'd2) return rd;
        mask = (32'd1 << nbits) - 32'd1;
        v = (rd >> (8 * int'(addr[1:0]))) & mask;
        if (sg && v[nbits-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic void count_cmd();
        if (avm_read || avm_write) last_cmd++;
        if (resp_valid) last_resp++;
    endfunction

    // One request; `waits` = cycles the slave holds waitrequest (>= T means stuck).
    task automatic xact(input logic wr, input logic [31:0] addr, input logic [1:0] sz,
                        input logic sg, input logic [31:0] wd, input int waits,
                        input logic [31:0] rd);
        logic err, exp_err;
        int   ncmd;
        last_cmd = 0; last_resp = 0;
        last_be = 4'd0; last_wd = 32'd0; last_addr = 32'd0;
        chk("ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_size = sz;
        req_signed = sg; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_write = $urandom; req_addr = $urandom;
        req_size = 2'($urandom); req_signed = $urandom; req_wdata = $urandom;
        err = m_err(addr, sz);
        exp_err = err;
        if (!err) begin
            ncmd = (waits >= T) ? T : waits + 1;
            exp_err = (waits >= T);
            for (int k = 0; k < ncmd; k++) begin
                count_cmd();
                if (k == 0) begin
                    last_be = avm_byteenable; last_wd = avm_writedata; last_addr = avm_address;
                end
                chk("bus_read", {31'd0, avm_read}, {31'd0, !wr});
                chk("bus_write", {31'd0, avm_write}, {31'd0, wr});
                chk("bus_addr", avm_address, {addr[31:2], 2'b00});
                chk("bus_be", {28'd0, avm_byteenable}, {28'd0, m_be(addr, sz)});
                if (wr) chk("bus_wdata", avm_writedata, m_wd(sz, wd));
                chk("bus_no_resp", {31'd0, resp_valid}, 32'd0);
                chk("bus_not_ready", {31'd0, req_ready}, 32'd0);
                avm_waitrequest = (k < waits);
                avm_readdata = (k < waits) ? $urandom : rd;
                @(negedge clk);
            end
        end
        avm_waitrequest = (waits >= T) ? 1'b1 : 1'($urandom);
        avm_readdata = $urandom;
        count_cmd();
        last_rdata = resp_rdata;
        last_err = resp_error;
        chk("resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("resp_error", {31'd0, resp_error}, {31'd0, exp_err});
        chk("resp_rdata", resp_rdata, (exp_err || wr) ? 32'd0 : m_rd(addr, sz, sg, rd));
        chk("resp_no_cmd", {30'd0, avm_read, avm_write}, 32'd0);
        chk("resp_not_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        count_cmd();
        chk("resp_one_cycle", {31'd0, resp_valid}, 32'd0);
        avm_waitrequest = 1'($urandom);
    endtask

    initial begin
        logic [31:0] a, w, r;
        logic [1:0]  s;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0;
        req_size = 2'd0; req_signed = 1'b0; req_wdata = 32'd0;
        avm_waitrequest = 1'b0; avm_readdata = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_cmd", {30'd0, avm_read, avm_write}, 32'd0);
        chk("rst_addr", avm_address, 32'd0);
        chk("rst_be", {28'd0, avm_byteenable}, 32'd0);
        chk("rst_wdata", avm_writedata, 32'd0);
        chk("rst_resp", {30'd0, resp_valid, resp_error}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

        // Directed cases with literal expectations.
        xact(1'b0, 32'hBFC00000, 2'd2, 1'b0, 32'd0, 0, 32'h24210000);
        chk("lit_word_rdata", last_rdata, 32'h24210000);
        chk("lit_word_be", {28'd0, last_be}, 32'h0000000F);
        chk("lit_word_cmd", last_cmd, 1);
        chk("lit_word_resp", last_resp, 1);
        xact(1'b0, 32'hBFC00007, 2'd0, 1'b1, 32'd0, 0, 32'h80FF0000);
        chk("lit_sbyte_be", {28'd0, last_be}, 32'h00000008);
        chk("lit_sbyte_rdata", last_rdata, 32'hFFFFFF80);
        xact(1'b0, 32'hBFC00007, 2'd0, 1'b0, 32'd0, 0, 32'h80FF0000);
        chk("lit_ubyte_rdata", last_rdata, 32'h00000080);
        xact(1'b1, 32'h00000102, 2'd1, 1'b0, 32'h0000ABCD, 3, 32'd0);
        chk("lit_half_be", {28'd0, last_be}, 32'h0000000C);
        chk("lit_half_wd", last_wd, 32'hABCDABCD);
        chk("lit_half_addr", last_addr, 32'h00000100);
        chk("lit_half_cmd", last_cmd, 4);
        chk("lit_half_resp", last_resp, 1);
        chk("lit_half_err", {31'd0, last_err}, 32'd0);
        xact(1'b0, 32'h00000006, 2'd2, 1'b0, 32'd0, 0, 32'h12345678);
        chk("lit_misal_cmd", last_cmd, 0);
        chk("lit_misal_err", {31'd0, last_err}, 32'd1);
        chk("lit_misal_rdata", last_rdata, 32'd0);
        xact(1'b1, 32'h00000010, 2'd3, 1'b0, 32'hFFFFFFFF, 0, 32'd0);
        chk("lit_size3_cmd", last_cmd, 0);
        chk("lit_size3_err", {31'd0, last_err}, 32'd1);
        xact(1'b0, 32'h00000200, 2'd2, 1'b0, 32'd0, 100, 32'd0);
        chk("lit_tmo_cmd", last_cmd, 4);
        chk("lit_tmo_err", {31'd0, last_err}, 32'd1);
        xact(1'b0, 32'h00000204, 2'd2, 1'b0, 32'd0, 1, 32'hCAFEF00D);
        chk("lit_after_tmo", last_rdata, 32'hCAFEF00D);
        chk("lit_after_tmo_err", {31'd0, last_err}, 32'd0);

        // Reset in the middle of a stalled transfer.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h00000300; req_size = 2'd2;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        avm_waitrequest = 1'b1;
        chk("mid_bus_read", {31'd0, avm_read}, 32'd1);
        reset = 1'b1;
        #1;
        chk("async_rst_read", {31'd0, avm_read}, 32'd0);
        chk("async_rst_resp", {31'd0, resp_valid}, 32'd0);
        chk("async_rst_ready", {31'd0, req_ready}, 32'd0);
        chk("async_rst_addr", avm_address, 32'd0);
        chk("async_rst_be", {28'd0, avm_byteenable}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        avm_waitrequest = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_abort_no_resp", {31'd0, resp_valid}, 32'd0);
            chk("post_abort_ready", {31'd0, req_ready}, 32'd1);
            chk("post_abort_no_cmd", {30'd0, avm_read, avm_write}, 32'd0);
        end

        // Randomized traffic.
        for (int n = 0; n < 200; n++) begin
            s = 2'($urandom_range(0, 3));
            a = $urandom;
            if (s != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << s) - 32'd1);
            w = $urandom;
            r = $urandom;
            xact(1'($urandom), a, s, 1'($urandom), w, $urandom_range(0, 5), r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/avalon_master_lsu.md
# avalon_master_lsu

Avalon-MM master bridging the MIPS core's fetch/load/store requests onto the 32-bit memory bus served by the RAM model and other bus slaves. Accepts one byte, halfword or word request at a time. Generates word-aligned address, byteenable and lane-shifted write data, then holds the bus request until `waitrequest` releases it. Returns right-aligned, optionally sign-extended read data with a one-cycle response strobe; misaligned, illegal and timed-out accesses return an error instead.

## Interface
- `TIMEOUT_CYCLES`, default 0: maximum cycles a request may sit in BUS; 0 disables the timeout.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  core request strobe.
- `req_ready`  out  1  high only in IDLE; a request is accepted on an edge where `req_valid & req_ready`.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_size`  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- `req_signed`  in  1  sign-extend load data (byte/half only).
- `req_wdata`  in  32  store data, right-aligned.
- `resp_valid`  out  1  one-cycle completion strobe.
- `resp_rdata`  out  32  load result, right-aligned; 0 for stores and errors.
- `resp_error`  out  1  valid with `resp_valid`: misaligned, illegal size or timeout.
- `avm_address`  out  32  `{req_addr[31:2],2'b00}`.
- `avm_read`, `avm_write`  out  1 each  Avalon commands; never both high.
- `avm_byteenable`  out  4  active byte lanes.
- `avm_writedata`  out  32  lane-shifted store data.
- `avm_waitrequest`  in  1  slave stall.
- `avm_readdata`  in  32  slave read data.

## Operation
- States: IDLE, BUS, RESP.
- IDLE:
  - `req_ready`=1.
  - On acceptance, register address, size, signed, write flag and data.
  - Go to RESP with error if: size 11, halfword with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - Otherwise go to BUS.
- Byte lanes (little-endian, `o`=`addr[1:0]`):
  - Byte: byteenable = `4'b0001<<o`, writedata = `{4{wdata[7:0]}}`.
  - Half: byteenable = `4'b0011<<o`, writedata = `{2{wdata[15:0]}}`.
  - Word: byteenable = `4'b1111`, writedata = `wdata`.
- BUS:
  - Assert `avm_read` or `avm_write`; address, byteenable and writedata are registered and held stable for the whole state.
  - An edge with `avm_waitrequest`=0 completes the transfer. For reads, `avm_readdata` is sampled on that edge; then go to RESP.
- Read extraction:
  - Byte: `readdata[8o+7:8o]`.
  - Half: `readdata[8o+15:8o]`.
  - Zero- or sign-extend to 32 bits per `req_signed`; word loads ignore `req_signed`.
- Timeout: when `TIMEOUT_CYCLES`≠0, a counter runs from 0 on BUS entry. If it reaches `TIMEOUT_CYCLES` with `waitrequest` still 1, drop the command and go to RESP with error.
- RESP:
  - `resp_valid`=1 for exactly one cycle; all bus commands are low; then return to IDLE.
  - This guarantees at least one idle bus cycle between back-to-back transactions, giving edge-triggered slaves a fresh rising edge.
- Reset, asynchronous and valid mid-transaction: state → IDLE and all outputs → 0 immediately. The outstanding transfer is abandoned with no response.

## Timing
- Reset values: `req_ready`=0 while reset is held, 1 in the first cycle after release. `avm_read`, `avm_write`, `avm_byteenable`, `avm_writedata`, `avm_address`, `resp_valid`, `resp_rdata`, `resp_error` are all 0.
- Zero-wait transfer, request accepted at edge E:
  - Command high in cycle E..E+1.
  - Completes at E+1.
  - `resp_valid` high in cycle E+1..E+2.
  - Next acceptance possible at E+3.
- N wait cycles add N cycles; command stays high for N+1 cycles.
- Error path: accepted at E, `resp_valid` in E..E+1, no bus activity.
- Timeout: command high for exactly `TIMEOUT_CYCLES` cycles, then the response follows.
- `req_valid` during BUS/RESP is ignored (`req_ready`=0); the core must hold it.
- `waitrequest` rising in IDLE/RESP is ignored.

## Test plan
- Word read at 0xBFC00000, slave returns 0x24210000 with 0 wait: `avm_read` high 1 cycle, byteenable 1111, `resp_rdata`=0x24210000 two cycles after acceptance.
- Signed byte load at 0xBFC00007, readdata 0x80FF0000: byteenable 1000, `resp_rdata`=0xFFFFFF80; unsigned gives 0x00000080.
- Half store 0xABCD at 0x00000102 with 3 wait cycles: byteenable 1100, writedata 0xABCDABCD, address 0x00000100, all held stable 4 cycles, one `resp_valid`, `resp_error`=0.
- Misaligned word at 0x00000006 and size 11: no `avm_read`/`avm_write`, `resp_error`=1, `resp_rdata`=0.
- `TIMEOUT_CYCLES`=4, waitrequest stuck high: read high exactly 4 cycles, then `resp_error`=1; the next request proceeds normally.
- Reset asserted mid-BUS: `avm_read`, `resp_valid` = 0 without a clock edge; no response after release; `req_ready`=1.
